// File: rtl/mem_ctrl.sv
// Purpose : serialises 32-bit fetch and data accesses onto an 8-bit synchronous-read RAM.
// Latency : request sampled in IDLE at cycle T -> read done at T+N+2, write done at T+N+1 (N = 1/2/4 bytes).
// Backpressure: requesters hold req high until their done pulse; stall outputs stay high until then.
//
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset
//   if_req_i/if_addr_i     instruction-fetch request (always a 4-byte read)
//   if_rdata_o/if_done_o   fetch result and one-cycle completion pulse; if_stall_o = req & ~done
//   mem_req_i/mem_we_i     data-access request and direction
//   mem_addr_i/mem_width_i byte address and size (00 byte, 01 half, 1x word)
//   mem_wdata_i            write data, little-endian, low bytes used
//   mem_rdata_o/mem_done_o data result and one-cycle completion pulse; mem_stall_o = req & ~done
//   ram_addr_o/ram_dout_o/ram_wr_o/ram_din_i   byte RAM port; ram_din_i arrives one cycle after its address
module mem_ctrl (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_done_o,
    output logic        if_stall_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [1:0]  mem_width_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_done_o,
    output logic        mem_stall_o,
    output logic [31:0] ram_addr_o,
    output logic [7:0]  ram_dout_o,
    output logic        ram_wr_o,
    input  logic [7:0]  ram_din_i
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_XFER = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  state_q,     state_d;
    logic [1:0]  k_q,         k_d;
    logic [1:0]  last_k_q,    last_k_d;     // N-1
    logic [31:0] base_q,      base_d;
    logic        we_q,        we_d;
    logic        is_if_q,     is_if_d;      // which requester is being served
    logic [31:0] wdata_q,     wdata_d;
    logic [31:0] acc_q,       acc_d;        // read bytes collected so far
    logic [31:0] if_rdata_q,  if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;

    logic        served_req;
    logic [1:0]  prev_k;
    logic [31:0] rd_final;

    assign served_req = is_if_q ? if_req_i : mem_req_i;
    // RAM returns the byte addressed in the previous cycle.
    assign prev_k     = k_q - 2'd1;

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        last_k_d    = last_k_q;
        base_d      = base_q;
        we_d        = we_q;
        is_if_d     = is_if_q;
        wdata_d     = wdata_q;
        acc_d       = acc_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        rd_final    = acc_q;

        case (state_q)
            S_IDLE: begin
                k_d   = 2'd0;
                acc_d = 32'h0;
                if (mem_req_i) begin
                    base_d  = mem_addr_i;
                    we_d    = mem_we_i;
                    wdata_d = mem_wdata_i;
                    is_if_d = 1'b0;
                    case (mem_width_i)
                        2'b00:   last_k_d = 2'd0;
                        2'b01:   last_k_d = 2'd1;
                        default: last_k_d = 2'd3;
                    endcase
                    state_d = S_XFER;
                end else if (if_req_i) begin
                    base_d   = if_addr_i;
                    we_d     = 1'b0;
                    wdata_d  = 32'h0;
                    is_if_d  = 1'b1;
                    last_k_d = 2'd3;
                    state_d  = S_XFER;
                end
            end

            S_XFER: begin
                if (!served_req) begin
                    state_d = S_IDLE;
                    k_d     = 2'd0;
                end else begin
                    if (!we_q && (k_q != 2'd0)) begin
                        acc_d[{prev_k, 3'b000} +: 8] = ram_din_i;
                    end
                    if (k_q == last_k_q) begin
                        state_d = we_q ? S_DONE : S_WAIT;
                        k_d     = 2'd0;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end

            S_WAIT: begin
                if (!served_req) begin
                    state_d = S_IDLE;
                end else begin
                    // Final byte goes straight into the result register so it is
                    // visible during the done cycle.
                    rd_final = acc_q;
                    rd_final[{last_k_q, 3'b000} +: 8] = ram_din_i;
                    acc_d = rd_final;
                    if (is_if_q) begin
                        if_rdata_d = rd_final;
                    end else begin
                        mem_rdata_d = rd_final;
                    end
                    state_d = S_DONE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            k_q         <= 2'd0;
            last_k_q    <= 2'd0;
            base_q      <= 32'h0;
            we_q        <= 1'b0;
            is_if_q     <= 1'b0;
            wdata_q     <= 32'h0;
            acc_q       <= 32'h0;
            if_rdata_q  <= 32'h0;
            mem_rdata_q <= 32'h0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            last_k_q    <= last_k_d;
            base_q      <= base_d;
            we_q        <= we_d;
            is_if_q     <= is_if_d;
            wdata_q     <= wdata_d;
            acc_q       <= acc_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    logic in_xfer;
    assign in_xfer = (state_q == S_XFER);

    // ram_addr wraps naturally through 32-bit addition.
    assign ram_addr_o = in_xfer ? (base_q + {30'b0, k_q}) : 32'h0;
    assign ram_wr_o   = in_xfer & we_q;
    assign ram_dout_o = (in_xfer & we_q) ? wdata_q[{k_q, 3'b000} +: 8] : 8'h00;

    assign if_done_o   = (state_q == S_DONE) &  is_if_q;
    assign mem_done_o  = (state_q == S_DONE) & ~is_if_q;
    assign if_rdata_o  = if_rdata_q;
    assign mem_rdata_o = mem_rdata_q;
    assign if_stall_o  = if_req_i  & ~if_done_o;
    assign mem_stall_o = mem_req_i & ~mem_done_o;

endmodule
